// File: rtl/hes_decipher.sv
// hes_decipher: receive-side HES byte-stream decipher.
//   Each accepted ciphertext byte is XORed with ks = SBOX(key ^ ctr), where
//   SBOX is the AES forward S-box and ctr is the byte index in the message.
//   Plaintext is queued in a small output FIFO so the consumer can stall.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   new_message, key         start-of-message pulse and its key
//   valid_in/ready_in/data_in    ciphertext input handshake
//   valid_out/ready_out/data_out plaintext output handshake
//   byte_count               bytes accepted in the current message (saturating)
//   err_no_msg               sticky: a byte arrived while no message was open
module hes_decipher #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             new_message,
  input  logic [7:0]       key,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [7:0]       data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [7:0]       data_out,
  output logic [CNT_W-1:0] byte_count,
  output logic             err_no_msg
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  // AES forward S-box; entry 0 sits in the most significant byte.
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TBL[~a];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state, state_nxt;
  logic [7:0]      key_reg;
  logic [7:0]      ctr;
  logic [7:0]      eff_key, eff_ctr;
  logic            accept, push, drop, pop;
  logic [7:0]      plain;
  logic [CNT_W-1:0] cnt_base;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_nxt;

  assign accept    = valid_in && ready_in;
  assign valid_out = (count != '0);
  assign pop       = valid_out && ready_out;
  assign data_out  = valid_out ? mem[rd_ptr] : 8'h00;
  // A new_message arriving with a byte makes that byte index 0 of the new message.
  assign cnt_base  = new_message ? '0 : byte_count;
  assign plain     = data_in ^ sbox(eff_key ^ eff_ctr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    eff_key   = key_reg;
    eff_ctr   = ctr;
    push      = 1'b0;
    drop      = 1'b0;
    if (new_message) begin
      state_nxt = ACTIVE;
      eff_key   = key;
      eff_ctr   = 8'h00;
    end
    if (accept) begin
      if (state == ACTIVE || new_message) push = 1'b1;
      else                                drop = 1'b1;
    end
  end

  always_comb begin
    count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_reg    <= 8'h00;
      ctr        <= 8'h00;
      byte_count <= '0;
      err_no_msg <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ready_in   <= 1'b0;
    end else begin
      if (new_message) key_reg <= key;
      if (push) begin
        ctr        <= eff_ctr + 8'd1;
        byte_count <= sat_inc(cnt_base);
        wr_ptr     <= wr_ptr + AW'(1);
      end else if (new_message) begin
        ctr        <= 8'h00;
        byte_count <= '0;
      end
      if (drop) err_no_msg <= 1'b1;
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      // Registered not-full: a pop only frees a slot for the following cycle.
      ready_in <= (count_nxt != CNT_FULL);
    end
  end

  // FIFO storage holds data only; emptiness is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= plain;
  end

endmodule

// File: tb/tb_hes_decipher.sv
module tb_hes_decipher;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          new_message = 1'b0;
  logic [7:0]    key = 8'h00;
  logic          valid_in = 1'b0;
  logic          ready_in;
  logic [7:0]    data_in = 8'h00;
  logic          valid_out;
  logic          ready_out = 1'b0;
  logic [7:0]    data_out;
  logic [CW-1:0] byte_count;
  logic          err_no_msg;

  hes_decipher #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .new_message(new_message), .key(key),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .byte_count(byte_count), .err_no_msg(err_no_msg)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference S-box derived from GF(2^8) inversion plus the AES affine map.
  logic [7:0] sbox_ref [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  // Behavioural model: message state plus a queue of pending plaintext.
  logic [7:0] q[$];
  bit         m_open, m_err, m_ready;
  logic [7:0] m_key;
  int         m_idx, m_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_open = 0; m_err = 0; m_ready = 0; m_key = 8'h00; m_idx = 0; m_cnt = 0;
    end else begin
      bit acc;
      acc = valid_in && m_ready;
      if (q.size() != 0 && ready_out) void'(q.pop_front());
      if (new_message) begin
        m_open = 1; m_key = key; m_idx = 0; m_cnt = 0;
      end
      if (acc) begin
        if (m_open) begin
          q.push_back(data_in ^ sbox_ref[(m_key ^ (m_idx % 256)) & 8'hff]);
          m_idx++;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end else begin
          m_err = 1;
        end
      end
      m_ready = (q.size() < DEPTH);
    end
  end

  always @(negedge clk) begin
    check_eq("ready_in", ready_in, m_ready);
    check_eq("valid_out", valid_out, q.size() != 0);
    if (q.size() != 0) check_eq("data_out", data_out, q[0]);
    check_eq("byte_count", byte_count, m_cnt);
    check_eq("err_no_msg", err_no_msg, m_err);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_msg(input logic [7:0] k);
    new_message = 1; key = k;
    tick();
    new_message = 0;
  endtask

  // Holds the byte until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] d, input bit nm, input logic [7:0] k);
    bit acc = 0;
    valid_in = 1; data_in = d; new_message = nm; key = k;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk); acc = ready_in;
      @(posedge clk); #1;
      new_message = 0;
    end
    valid_in = 0;
    if (!acc) check_eq("send_timeout", acc, 1);
  endtask

  logic [7:0] t1 [4] = '{8'h82, 8'hca, 8'h7d, 8'hc9};

  initial begin
    build_sbox();
    check_eq("sbox_ref_11", sbox_ref[8'h11], 8'h82);

    // Reset state
    #2;
    check_eq("rst_ready_in", ready_in, 0);
    check_eq("rst_valid_out", valid_out, 0);
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_byte_count", byte_count, 0);
    check_eq("rst_err", err_no_msg, 0);
    tick();
    reset_n = 1;
    check_eq("rel_ready_in_low", ready_in, 0);
    tick();
    check_eq("rel_ready_in_high", ready_in, 1);

    // Basic message under key 0x11
    ready_out = 1;
    pulse_msg(8'h11);
    foreach (t1[i]) begin
      send(t1[i], 0, 8'h00);
      check_eq("t1_valid", valid_out, 1);
      check_eq("t1_data", data_out, 8'h00);
    end
    check_eq("t1_count", byte_count, 4);

    // new_message together with byte 0
    send(8'h83, 1, 8'h11);
    check_eq("t2_data", data_out, 8'h01);
    check_eq("t2_count", byte_count, 1);
    tick();

    // Backpressure fills FIFO
    ready_out = 0;
    pulse_msg(8'h11);
    foreach (t1[i]) send(t1[i], 0, 8'h00);
    check_eq("t3_full", ready_in, 0);
    valid_in = 1; data_in = 8'h59;
    repeat (3) tick();
    check_eq("t3_hold_valid", valid_out, 1);
    check_eq("t3_hold_data", data_out, 8'h00);
    check_eq("t3_hold_count", byte_count, 4);
    check_eq("t3_hold_ready", ready_in, 0);
    ready_out = 1;
    send(8'h59, 0, 8'h00);
    check_eq("t3_count5", byte_count, 5);
    repeat (6) tick();
    check_eq("t3_drained", valid_out, 0);

    // Byte with no message open
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
    send(8'h55, 0, 8'h00);
    check_eq("t4_no_push", valid_out, 0);
    check_eq("t4_err", err_no_msg, 1);
    pulse_msg(8'h22);
    check_eq("t4_err_sticky", err_no_msg, 1);

    // Restart mid-message with a byte in the same cycle
    pulse_msg(8'h11);
    send(8'h82, 0, 8'h00);
    send(8'hca, 0, 8'h00);
    send(8'hca, 1, 8'h10);
    check_eq("t5_data0", data_out, 8'h00);
    check_eq("t5_count1", byte_count, 1);
    send(8'h82, 0, 8'h00);
    check_eq("t5_data1", data_out, 8'h00);
    check_eq("t5_count2", byte_count, 2);

    // Counter wrap, then reset mid-drain
    pulse_msg(8'h11);
    repeat (257) send(8'h82, 0, 8'h00);
    check_eq("t6_wrap_data", data_out, 8'h00);
    check_eq("t6_count", byte_count, 257);
    #2 reset_n = 0;
    #1;
    check_eq("t6_rst_valid", valid_out, 0);
    check_eq("t6_rst_count", byte_count, 0);
    check_eq("t6_rst_ready", ready_in, 0);
    check_eq("t6_rst_data", data_out, 0);
    tick();
    reset_n = 1;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      new_message = ($urandom_range(0, 39) == 0);
      key         = 8'($urandom);
      valid_in    = ($urandom_range(0, 3) != 0);
      data_in     = 8'($urandom);
      ready_out   = ($urandom_range(0, 2) != 0);
      tick();
    end
    new_message = 0; valid_in = 0; ready_out = 1;
    repeat (8) tick();
    check_eq("final_empty", valid_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/hes_decipher.md
Name: hes_decipher

Overview:
- Receive-side counterpart of the HES byte-stream cipher. Consumes ciphertext bytes and returns plaintext bytes.
- Uses the same keystream as the transmit cipher: ks_i = SBOX(key ^ ctr_i), where SBOX is the standard AES forward S-box and ctr_i is the 8-bit byte index within the message.
- Sits between the link receiver and the consumer.
- Adds valid/ready flow control on both sides and an output FIFO, so the consumer can stall without losing bytes.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2
CNT_W, 16, width of byte_count

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
new_message  input  1  single-cycle pulse; starts a message and latches key
key  input  8  message key, sampled only when new_message=1
valid_in  input  1  ciphertext byte present
ready_in  output  1  block can accept a byte
data_in  input  8  ciphertext byte
valid_out  output  1  plaintext byte present
ready_out  input  1  consumer accepts a byte
data_out  output  8  plaintext byte
byte_count  output  CNT_W  bytes accepted in the current message
err_no_msg  output  1  sticky: a byte arrived with no message open

Behaviour:
- Reset values (async on reset_n=0):
  - state=IDLE, key_reg=0, ctr=0, FIFO empty.
  - ready_in=0 while reset is asserted, then 1 from the first clock after release.
  - valid_out=0, data_out=0, byte_count=0, err_no_msg=0.
- FSM states: IDLE and ACTIVE.
  - new_message=1 in any state: key_reg<=key, ctr<=0, byte_count<=0, state<=ACTIVE.
  - No other transitions. ACTIVE persists until reset or the next new_message, which restarts the message.
- Accept condition: valid_in && ready_in at a rising edge.
- Keystream selection on an accepted byte:
  - Normal case: eff_key=key_reg, eff_ctr=ctr.
  - If new_message is asserted in the same cycle: eff_key=key port and eff_ctr=0. The byte is byte 0 of the new message.
- Decryption on an accepted byte while ACTIVE, or with new_message=1:
  - Compute data_in ^ SBOX(eff_key ^ eff_ctr) and push it into the FIFO.
  - ctr<=eff_ctr+1, wrapping 255->0 modulo 256.
  - byte_count<=(value after any new_message clear)+1, saturating at all-ones.
- Accepted byte in IDLE without new_message: discarded (not pushed), err_no_msg<=1. err_no_msg clears only on reset.
- ready_in is the registered not-full flag.
  - ready_in=0 when FIFO holds FIFO_DEPTH entries.
  - A pop in the same cycle does not allow a push in that cycle. ready_in rises the cycle after the pop.
- Latency: a byte accepted at edge N into an empty FIFO gives valid_out=1 with its plaintext on data_out in the cycle after edge N. This is 1-cycle latency.
- Output handshake:
  - A pop occurs on valid_out && ready_out at an edge.
  - While valid_out=1 and ready_out=0, data_out and valid_out hold stable.
  - Output order equals acceptance order.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur and occupancy is unchanged.
- Bytes still queued when new_message arrives keep the plaintext computed under the old key and drain normally.
- Reset mid-operation: FIFO contents are lost and all outputs return to their reset values immediately.
- SBOX is a combinational 256-entry ROM. There is no other pipelining.

Test Plan:
1. Reset, then new_message=1 with key=0x11. Next cycles feed ciphertext 82, ca, 7d, c9 with ready_out=1 -> data_out 00, 00, 00, 00, each valid one cycle after acceptance; byte_count=4.
2. new_message=1 with key=0x11, ciphertext 0x83 in the same cycle -> data_out=0x01, byte_count=1.
3. ready_out=0, feed 5 bytes of a key=0x11 message (82 ca 7d c9 xx) -> ready_in=0 after the 4th accept, 5th byte held by the source, data_out stays 00. Then ready_out=1 -> four 00 bytes drain in order, ready_in returns to 1, 5th byte accepted.
4. valid_in=1 with data 0x55 before any new_message -> byte dropped, valid_out stays 0, err_no_msg=1 and remains 1 after a later new_message.
5. Mid-message (key 0x11, ctr=2), new_message with key=0x10 and ciphertext 0xca in the same cycle -> data_out=0x00, byte_count=1. Next ciphertext 0x82 -> data_out=0x00 (SBOX(0x11)=0x82).
6. key=0x11, 257 bytes of 0x82 -> byte 257 (ctr wrapped to 0) yields 0x00 and byte_count=257. Then assert reset_n=0 mid-drain -> valid_out=0, byte_count=0, ready_in=0 immediately.
